// File: rtl/alu.sv
// alu: single-stage registered RV32I integer/branch-compare unit; broadcasts
// {value, ROB id} one cycle after issue on the ALU result bus.
module alu #(
    parameter int CALC_OP_L1_NUM_WIDTH = 4,
    parameter int ROB_SIZE_WIDTH       = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            need_flush_in,
    input  logic                            rs2alu_ready,
    input  logic [CALC_OP_L1_NUM_WIDTH-1:0] rs2alu_op_L1,
    input  logic                            rs2alu_op_L2,
    input  logic [31:0]                     rs2alu_opr1,
    input  logic [31:0]                     rs2alu_opr2,
    input  logic [ROB_SIZE_WIDTH-1:0]       rs2alu_rob_id,
    output logic                            alu_valid,
    output logic [31:0]                     alu_value,
    output logic [ROB_SIZE_WIDTH-1:0]       alu_dependency
);
    logic                      valid_q, valid_d, issue;
    logic [31:0]               value_q, value_d, res;
    logic [ROB_SIZE_WIDTH-1:0] dep_q, dep_d;
    logic [4:0]                sh;
    logic                      lt_s, lt_u, eq;

    always_comb begin
        sh   = rs2alu_opr2[4:0];
        lt_s = $signed(rs2alu_opr1) < $signed(rs2alu_opr2);
        lt_u = rs2alu_opr1 < rs2alu_opr2;
        eq   = rs2alu_opr1 == rs2alu_opr2;
        res  = '0;
        case (rs2alu_op_L1)
            'd0:  res = rs2alu_op_L2 ? rs2alu_opr1 - rs2alu_opr2 : rs2alu_opr1 + rs2alu_opr2;
            'd1:  res = rs2alu_opr1 << sh;
            'd2:  res = {31'd0, lt_s};
            'd3:  res = {31'd0, lt_u};
            'd4:  res = rs2alu_opr1 ^ rs2alu_opr2;
            'd5:  res = rs2alu_op_L2 ? 32'($signed(rs2alu_opr1) >>> sh) : rs2alu_opr1 >> sh;
            'd6:  res = rs2alu_opr1 | rs2alu_opr2;
            'd7:  res = rs2alu_opr1 & rs2alu_opr2;
            'd8:  res = {31'd0, eq ^ rs2alu_op_L2};
            'd9:  res = {31'd0, lt_s ^ rs2alu_op_L2};
            'd10: res = {31'd0, lt_u ^ rs2alu_op_L2};
            default: res = '0;
        endcase
        // freeze and flush both suppress the issue; value/dependency then hold
        issue   = rdy_in && !need_flush_in && rs2alu_ready;
        valid_d = issue;
        value_d = issue ? res : value_q;
        dep_d   = issue ? rs2alu_rob_id : dep_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            value_q <= '0;
            dep_q   <= '0;
        end else begin
            valid_q <= valid_d;
            value_q <= value_d;
            dep_q   <= dep_d;
        end
    end

    assign alu_valid      = valid_q;
    assign alu_value      = value_q;
    assign alu_dependency = dep_q;
endmodule
